// File: rtl/branch_gen_unit.sv
// Branch generation unit: decodes direct branches in the fetched pair and steers fetch.
// Optional BL decode as an always-taken branch is enabled by defining BGU_BL_EN.
module branch_gen_unit #(
  parameter int PCW = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [PCW-1:0] PC,
  input  logic           fetch_next_in,
  input  logic [15:0]    p0_IR_in,
  input  logic [15:0]    p1_IR_in,
  input  logic           N,
  input  logic           V,
  input  logic           Z,
  output logic [PCW-1:0] PC_next_out,
  output logic           IR0_invalid_out,
  output logic           reset_S1,
  output logic           is_p0_b
);

  logic [PCW-1:0] pair_pc_q, pair_pc_d;
  logic           flush_q, flush_d;
  logic           odd_pend_q, odd_pend_d;
  logic           odd_now_q, odd_now_d;

  logic           v0, v1;
  logic           take0, take1;
  logic [PCW-1:0] tgt0, tgt1;
  logic [PCW-2:0] seq_hi;

  function automatic logic br_taken(
    input logic [15:0] ir,
    input logic        n,
    input logic        v,
    input logic        z
  );
    logic t;
    t = 1'b0;
    if (ir[15:11] == 5'b00100) begin
      case (ir[10:8])
        3'b000:  t = 1'b1;
        3'b001:  t = z;
        3'b010:  t = !z;
        3'b011:  t = n ^ v;
        3'b100:  t = (n ^ v) | z;
        default: t = 1'b0;
      endcase
    end
`ifdef BGU_BL_EN
    if (ir[15:11] == 5'b01011) t = 1'b1;
`else
`endif
    return t;
  endfunction

  function automatic logic [PCW-1:0] sx8(input logic [7:0] im);
    return {{(PCW-8){im[7]}}, im};
  endfunction

  always_comb begin
    v0     = !flush_q && !IR0_invalid_out;
    v1     = !flush_q && !take0;
    take0  = 1'b0;
    take1  = 1'b0;
    tgt0   = pair_pc_q + PCW'(1) + sx8(p0_IR_in[7:0]);
    tgt1   = pair_pc_q + PCW'(2) + sx8(p1_IR_in[7:0]);
    seq_hi = PC[PCW-1:1] + (PCW-1)'(1);
    take0  = v0 && br_taken(p0_IR_in, N, V, Z);
    v1     = !flush_q && !take0;
    take1  = v1 && br_taken(p1_IR_in, N, V, Z);
    unique case (1'b1)
      take0:   PC_next_out = tgt0;
      take1:   PC_next_out = tgt1;
      default: PC_next_out = {seq_hi, 1'b0};
    endcase
  end

  assign reset_S1        = flush_q;
  assign IR0_invalid_out = odd_now_q && !flush_q;
  assign is_p0_b         = take0;

  always_comb begin
    pair_pc_d  = pair_pc_q;
    flush_d    = flush_q;
    odd_pend_d = odd_pend_q;
    odd_now_d  = odd_now_q;
    if (fetch_next_in) begin
      pair_pc_d  = PC & ~PCW'(1);
      flush_d    = take0 | take1;
      odd_pend_d = (take0 | take1) & PC_next_out[0];
      odd_now_d  = odd_pend_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_pc_q  <= '0;
      flush_q    <= 1'b1;
      odd_pend_q <= 1'b0;
      odd_now_q  <= 1'b0;
    end else begin
      pair_pc_q  <= pair_pc_d;
      flush_q    <= flush_d;
      odd_pend_q <= odd_pend_d;
      odd_now_q  <= odd_now_d;
    end
  end

endmodule

// File: tb/tb_branch_gen_unit.sv
// Directed scoreboard bench for branch_gen_unit.
module tb_branch_gen_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  PC;
  logic        fetch_next_in;
  logic [15:0] p0_IR_in, p1_IR_in;
  logic        N, V, Z;
  logic [8:0]  PC_next_out;
  logic        IR0_invalid_out, reset_S1, is_p0_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [8:0] nxt;
    logic       inv;
    logic       rs1;
    logic       isb;
    string      nm;
  } exp_t;

  exp_t sb[$];

  localparam logic [15:0] NOP = 16'h0000;

  branch_gen_unit #(.PCW(9)) dut (
    .clk(clk), .rst(rst), .PC(PC),
    .fetch_next_in(fetch_next_in),
    .p0_IR_in(p0_IR_in), .p1_IR_in(p1_IR_in),
    .N(N), .V(V), .Z(Z),
    .PC_next_out(PC_next_out),
    .IR0_invalid_out(IR0_invalid_out),
    .reset_S1(reset_S1), .is_p0_b(is_p0_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (PC_next_out !== e.nxt || IR0_invalid_out !== e.inv ||
          reset_S1 !== e.rs1 || is_p0_b !== e.isb) begin
        errors++;
        $display("FAIL %s: got next=%h inv=%b rs1=%b isb=%b want next=%h inv=%b rs1=%b isb=%b",
                 e.nm, PC_next_out, IR0_invalid_out, reset_S1, is_p0_b,
                 e.nxt, e.inv, e.rs1, e.isb);
      end
    end
  end

  task automatic step(
    input logic        r,
    input logic [8:0]  pc,
    input logic [15:0] i0,
    input logic [15:0] i1,
    input logic [2:0]  nvz,
    input logic        f,
    input logic [8:0]  en,
    input logic        ei,
    input logic        er,
    input logic        eb,
    input string       nm
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    PC = pc;
    p0_IR_in = i0;
    p1_IR_in = i1;
    {N, V, Z} = nvz;
    fetch_next_in = f;
    e.nxt = en; e.inv = ei; e.rs1 = er; e.isb = eb; e.nm = nm;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b0;
    PC = '0;
    fetch_next_in = 1'b1;
    p0_IR_in = NOP;
    p1_IR_in = NOP;
    {N, V, Z} = 3'b000;

    // reset and sequential fetch
    step(0, 9'd0,  NOP, NOP, 3'b000, 1, 9'd2,  0, 1, 0, "in_reset");
    step(1, 9'd0,  NOP, NOP, 3'b000, 1, 9'd2,  0, 1, 0, "first_after_reset");
    step(1, 9'd2,  NOP, NOP, 3'b000, 1, 9'd4,  0, 0, 0, "seq_2");
    step(1, 9'd4,  NOP, NOP, 3'b000, 1, 9'd6,  0, 0, 0, "seq_4");
    // B +3 in p0 at pair_pc=4
    step(1, 9'd6,  16'h2003, NOP, 3'b000, 1, 9'd8,  0, 0, 1, "b_p0_taken");
    step(1, 9'd8,  16'h2003, NOP, 3'b000, 1, 9'd10, 0, 1, 0, "b_wrong_path");
    step(1, 9'd10, NOP, NOP, 3'b000, 1, 9'd12, 0, 0, 0, "b_target_even");
    // BEQ +2 in p1, Z=0 then Z=1
    step(1, 9'd4,  NOP, NOP, 3'b000, 1, 9'd6,  0, 0, 0, "seq_4b");
    step(1, 9'd6,  NOP, 16'h2102, 3'b000, 1, 9'd8, 0, 0, 0, "beq_p1_nt");
    step(1, 9'd4,  NOP, NOP, 3'b000, 1, 9'd6,  0, 0, 0, "beq_no_flush");
    step(1, 9'd6,  NOP, 16'h2102, 3'b001, 1, 9'd8, 0, 0, 0, "beq_p1_taken");
    step(1, 9'd8,  NOP, NOP, 3'b000, 1, 9'd10, 0, 1, 0, "beq_flush");
    // odd target 5
    step(1, 9'd0,  NOP, NOP, 3'b000, 1, 9'd2,  0, 0, 0, "seq_0");
    step(1, 9'd2,  16'h2004, NOP, 3'b000, 1, 9'd5, 0, 0, 1, "odd_tgt");
    step(1, 9'd5,  NOP, NOP, 3'b000, 1, 9'd6,  0, 1, 0, "odd_flush");
    step(1, 9'd6,  16'h2003, NOP, 3'b000, 1, 9'd8, 1, 0, 0, "odd_p0_killed");
    step(1, 9'd8,  NOP, NOP, 3'b000, 1, 9'd10, 0, 0, 0, "odd_cleared");
    // B -2 wraps to 0x1FF
    step(1, 9'd0,  NOP, NOP, 3'b000, 1, 9'd2,  0, 0, 0, "seq_0b");
    step(1, 9'd2,  16'h20FE, NOP, 3'b000, 1, 9'h1FF, 0, 0, 1, "wrap_tgt");
    step(1, 9'h1FF, NOP, NOP, 3'b000, 1, 9'd0, 0, 1, 0, "wrap_seq");
    step(1, 9'd0,  NOP, NOP, 3'b000, 1, 9'd2,  1, 0, 0, "wrap_odd_inv");
    // stall with a taken branch, then flag change during stall
    step(1, 9'd2,  16'h2003, NOP, 3'b000, 0, 9'd4, 0, 0, 1, "stall_1");
    step(1, 9'd2,  16'h2003, NOP, 3'b000, 0, 9'd4, 0, 0, 1, "stall_2");
    step(1, 9'd2,  16'h2003, NOP, 3'b000, 0, 9'd4, 0, 0, 1, "stall_3");
    step(1, 9'd2,  16'h2105, NOP, 3'b000, 0, 9'd4, 0, 0, 0, "stall_beq_nt");
    step(1, 9'd2,  16'h2105, NOP, 3'b001, 1, 9'd6, 0, 0, 1, "stall_beq_adv");
    step(1, 9'd6,  NOP, NOP, 3'b000, 1, 9'd8,  0, 1, 0, "stall_flush");
    // BLT in p0, BLE in p1 behind an undefined cond
    step(1, 9'd8,  NOP, NOP, 3'b000, 1, 9'd10, 0, 0, 0, "seq_8");
    step(1, 9'd10, 16'h2301, NOP, 3'b100, 1, 9'd10, 0, 0, 1, "blt_taken");
    step(1, 9'd10, NOP, NOP, 3'b000, 1, 9'd12, 0, 1, 0, "blt_flush");
    step(1, 9'd12, 16'h2501, 16'h2402, 3'b001, 1, 9'd14, 0, 0, 0, "ble_p1");
    step(1, 9'd14, NOP, NOP, 3'b000, 1, 9'd16, 0, 1, 0, "ble_flush");
`ifdef BGU_BL_EN
    step(1, 9'd16, 16'h5801, NOP, 3'b000, 1, 9'd16, 0, 0, 1, "bl_taken");
    step(1, 9'd18, NOP, NOP, 3'b000, 1, 9'd20, 0, 1, 0, "bl_after");
`else
    step(1, 9'd16, 16'h5801, NOP, 3'b000, 1, 9'd18, 0, 0, 0, "bl_not_branch");
    step(1, 9'd18, NOP, NOP, 3'b000, 1, 9'd20, 0, 0, 0, "bl_after");
`endif
    // reset in the middle of an odd redirect
    step(1, 9'd20, 16'h2004, NOP, 3'b000, 1, 9'd23, 0, 0, 1, "mid_tgt");
    step(0, 9'd23, NOP, NOP, 3'b000, 1, 9'd24, 0, 1, 0, "mid_reset");
    step(1, 9'd0,  NOP, NOP, 3'b000, 1, 9'd2,  0, 1, 0, "mid_release");
    step(1, 9'd2,  NOP, NOP, 3'b000, 1, 9'd4,  0, 0, 0, "mid_odd_cleared");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_gen_unit.md
Name: branch_gen_unit

Overview:
- Branch generation unit for the dual-issue 16-bit core.
- Each cycle the core fetches an instruction pair, slot p0 at an even address and slot p1 at the following odd address. The unit decodes direct branches in that pair, evaluates conditions against the current N/V/Z flags, and produces the next fetch PC.
- It also generates slot-kill signals: the instruction after a taken p0 branch, the wrong-path pair already in flight after a redirect, and the even slot when the branch target is odd.
- It sits between the PC register / instruction memory and Stage 1 of both pipelines.

Parameters:
- PCW, 9, width of PC and PC_next_out.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- PC  in  PCW  current fetch PC (address driven to the IM this cycle).
- fetch_next_in  in  1  fetch advance; the PC register and the IM load only when this is 1.
- p0_IR_in  in  16  instruction in slot p0 (even address).
- p1_IR_in  in  16  instruction in slot p1 (odd address).
- N  in  1  current negative flag.
- V  in  1  current overflow flag.
- Z  in  1  current zero flag.
- PC_next_out  out  PCW  next fetch PC.
- IR0_invalid_out  out  1  slot p0 of the presented pair is invalid (branch target was odd).
- reset_S1  out  1  both slots of the presented pair are invalid (wrong path, or first cycle after reset).
- is_p0_b  out  1  slot p0 is a taken branch; slot p1 must be killed.

Behaviour:
- IM read is synchronous: the pair presented on p0_IR_in/p1_IR_in was addressed by PC one fetch earlier.
- State registers: pair_pc (PCW), flush (1), odd_pend (1), odd_now (1).
- All state registers update only on edges where fetch_next_in=1; otherwise they hold.
- Reset values: pair_pc=0, flush=1, odd_pend=0, odd_now=0.
- Outputs during and right after reset: reset_S1=1, IR0_invalid_out=0, is_p0_b=0.
- Branch decode (per slot):
  - branch iff IR[15:11]=00100; cond=IR[10:8]; im8=IR[7:0] sign-extended to PCW.
  - cond 000 (B): always taken.
  - cond 001 (BEQ): taken if Z.
  - cond 010 (BNE): taken if !Z.
  - cond 011 (BLT): taken if N!=V.
  - cond 100 (BLE): taken if (N!=V)|Z.
  - cond 101..111: not a branch.
- Slot validity:
  - p0 valid = !reset_S1 & !IR0_invalid_out.
  - p1 valid = !reset_S1 & !is_p0_b.
- Taken and target, combinational:
  - take0 = p0 valid & p0 branch taken; target0 = pair_pc + 1 + sx(im8_p0).
  - take1 = p1 valid & !take0 & p1 branch taken; target1 = pair_pc + 2 + sx(im8_p1).
  - p0 has priority over p1.
- Outputs, combinational:
  - is_p0_b = take0.
  - PC_next_out = target0 if take0; target1 if take1; otherwise {PC[PCW-1:1]+1, 1'b0}.
  - reset_S1 = flush.
  - IR0_invalid_out = odd_now & !flush.
- On an edge with fetch_next_in=1:
  - pair_pc <= {PC[PCW-1:1], 1'b0}.
  - flush <= take0 | take1.
  - odd_pend <= (take0|take1) & PC_next_out[0].
  - odd_now <= odd_pend.
- Timing of a redirect: the wrong-path pair arrives one fetch after the taken branch and is killed by reset_S1. The target pair arrives two fetches after the branch, with IR0_invalid_out=1 if the target address is odd.
- Arithmetic is unsigned modulo 2^PCW; wrap-around is silent.
- Stall (fetch_next_in=0): the IR inputs are held by the IM, so the same decision is re-evaluated each cycle and no state changes.
- A flag change during a stall may change the decision; the value present on the advancing edge wins.
- Reset asserted mid-redirect: all pending flush/odd state is cleared and the post-reset flush is applied.

Optional Feature:
- Macro BGU_BL_EN.
- Defined: IR[15:11]=01011 (BL) is also decoded as an always-taken direct branch, with the same target formula and slot rules. Link-register write stays in the pipeline.
- Undefined: BL is not a branch for this unit.

Test Plan:
- Reset then release with fetch_next_in=1, non-branch pairs:
  - First cycle reset_S1=1, then 0.
  - PC=4 gives PC_next_out=6.
- p0=0x2003 (B +3) at pair_pc=4:
  - is_p0_b=1, PC_next_out=8.
  - Next cycle reset_S1=1; the cycle after, IR0_invalid_out=0.
- p1=0x2102 (BEQ +2), pair_pc=4:
  - Z=0: PC_next_out=PC+2, no flush.
  - Z=1: PC_next_out=8.
- p0=0x2004 at pair_pc=0: target 5; PC_next_out=5; two fetches later IR0_invalid_out=1.
- p0=0x20FE (B -2) at pair_pc=0: target 0x1FF (wrap).
- Taken branch with fetch_next_in=0 for 3 cycles: outputs stable, no flush; flush appears only after fetch_next_in=1.
